// File: rtl/calendar_pkg.sv
// calendar_pkg: field widths, limits, month names and month length.
// Shared by the calendar counter, its interface and leap checker.
package calendar_pkg;

  localparam int CENTI_W = 7;
  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int DATE_W  = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 14;
  localparam int DAY_W   = 3;

  localparam logic [CENTI_W-1:0] CENTI_MAX = 7'd99;
  localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;
  localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;
  localparam logic [HOUR_W-1:0]  HOUR_MAX  = 5'd23;
  localparam logic [DAY_W-1:0]   DAY_MAX   = 3'd6;

  localparam logic [MONTH_W-1:0] JAN = 4'd1;
  localparam logic [MONTH_W-1:0] FEB = 4'd2;
  localparam logic [MONTH_W-1:0] APR = 4'd4;
  localparam logic [MONTH_W-1:0] JUN = 4'd6;
  localparam logic [MONTH_W-1:0] SEP = 4'd9;
  localparam logic [MONTH_W-1:0] NOV = 4'd11;
  localparam logic [MONTH_W-1:0] DEC = 4'd12;
  localparam logic [MONTH_W-1:0] MONTH_MAX = DEC;

  // Out-of-range months return 31; callers range-check month.
  function automatic logic [DATE_W-1:0] daysInMonth(
    input logic [MONTH_W-1:0] month,
    input logic               leap
  );
    logic [DATE_W-1:0] n;
    case (month)
      FEB:                n = leap ? 5'd29 : 5'd28;
      APR, JUN, SEP, NOV: n = 5'd30;
      default:            n = 5'd31;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/calendar_time_counter_if.sv
// calendar_time_counter_if: tick/load inputs and display outputs.
// master = upstream/display side, slave = counter; CALENDAR_ALARM_EN adds alarm.
interface calendar_time_counter_if;
  import calendar_pkg::*;

  logic                 tick100Hz;
  logic                 load;
  logic [HOUR_W-1:0]    loadHours;
  logic [MIN_W-1:0]     loadMinutes;
  logic [SEC_W-1:0]     loadSeconds;
  logic [DATE_W-1:0]    loadDate;
  logic [MONTH_W-1:0]   loadMonth;
  logic [YEAR_W-1:0]    loadYear;
  logic [DAY_W-1:0]     loadDay;
  logic [CENTI_W-1:0]   centiDisplay;
  logic [SEC_W-1:0]     secondsDisplay;
  logic [MIN_W-1:0]     minutesDisplay;
  logic [HOUR_W-1:0]    hoursDisplay;
  logic [DATE_W-1:0]    dateDisplay;
  logic [MONTH_W-1:0]   monthDisplay;
  logic [YEAR_W-1:0]    yearDisplay;
  logic [DAY_W-1:0]     dayDisplay;
  logic                 secondPulse;
  logic                 dayRollover;
  logic                 loadError;
`ifdef CALENDAR_ALARM_EN
  logic                 alarmSet;
  logic [HOUR_W-1:0]    alarmHours;
  logic [MIN_W-1:0]     alarmMinutes;
  logic                 alarmEnable;
  logic                 alarmRing;
`endif

`ifdef CALENDAR_ALARM_EN
  modport master (
    output tick100Hz, load, loadHours, loadMinutes,
    output loadSeconds, loadDate, loadMonth, loadYear, loadDay,
    output alarmSet, alarmHours, alarmMinutes, alarmEnable,
    input  centiDisplay, secondsDisplay, minutesDisplay,
    input  hoursDisplay, dateDisplay, monthDisplay,
    input  yearDisplay, dayDisplay,
    input  secondPulse, dayRollover, loadError, alarmRing
  );
  modport slave (
    input  tick100Hz, load, loadHours, loadMinutes,
    input  loadSeconds, loadDate, loadMonth, loadYear, loadDay,
    input  alarmSet, alarmHours, alarmMinutes, alarmEnable,
    output centiDisplay, secondsDisplay, minutesDisplay,
    output hoursDisplay, dateDisplay, monthDisplay,
    output yearDisplay, dayDisplay,
    output secondPulse, dayRollover, loadError, alarmRing
  );
`else
  modport master (
    output tick100Hz, load, loadHours, loadMinutes,
    output loadSeconds, loadDate, loadMonth, loadYear, loadDay,
    input  centiDisplay, secondsDisplay, minutesDisplay,
    input  hoursDisplay, dateDisplay, monthDisplay,
    input  yearDisplay, dayDisplay,
    input  secondPulse, dayRollover, loadError
  );
  modport slave (
    input  tick100Hz, load, loadHours, loadMinutes,
    input  loadSeconds, loadDate, loadMonth, loadYear, loadDay,
    output centiDisplay, secondsDisplay, minutesDisplay,
    output hoursDisplay, dateDisplay, monthDisplay,
    output yearDisplay, dayDisplay,
    output secondPulse, dayRollover, loadError
  );
`endif

endinterface

// File: rtl/leap_year_check.sv
// leap_year_check: combinational Gregorian leap-year test.
// Ports: year (in), leap (out).
module leap_year_check
  import calendar_pkg::*;
(
  input  logic [YEAR_W-1:0] year,
  output logic              leap
);

  logic div4, div100, div400;

  always_comb begin
    div4   = (year[1:0] == 2'b00);
    div100 = ((year % YEAR_W'(100)) == '0);
    div400 = ((year % YEAR_W'(400)) == '0);
    leap   = (div4 && !div100) || div400;
  end

endmodule

// File: rtl/calendar_time_counter.sv
// calendar_time_counter: 100 Hz tick -> time of day and calendar.
// Ports: clockSignal, resetN, bus (slave); alarm under CALENDAR_ALARM_EN.
module calendar_time_counter
  import calendar_pkg::*;
#(
  parameter int RESET_YEAR = 1970,
  parameter int RESET_DAY  = 4,
  parameter int YEAR_MAX   = 9999
) (
  input logic                    clockSignal,
  input logic                    resetN,
  calendar_time_counter_if.slave bus
);

  localparam logic [YEAR_W-1:0] YR_RST = YEAR_W'(RESET_YEAR);
  localparam logic [YEAR_W-1:0] YR_END = YEAR_W'(YEAR_MAX);
  localparam logic [DAY_W-1:0]  DW_RST = DAY_W'(RESET_DAY);

  logic [CENTI_W-1:0] centi_q, centi_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [MIN_W-1:0]   min_q, min_d;
  logic [HOUR_W-1:0]  hour_q, hour_d;
  logic [DATE_W-1:0]  date_q, date_d;
  logic [MONTH_W-1:0] month_q, month_d;
  logic [YEAR_W-1:0]  year_q, year_d;
  logic [DAY_W-1:0]   day_q, day_d;
  logic sp_q, sp_d, roll_q, roll_d, err_q, err_d;

  logic run_leap, ld_leap;
  logic [DATE_W-1:0] run_dim, ld_dim;
  logic ld_ok;

  leap_year_check u_run_leap (
    .year (year_q),
    .leap (run_leap)
  );

  leap_year_check u_ld_leap (
    .year (bus.loadYear),
    .leap (ld_leap)
  );

  assign run_dim = daysInMonth(month_q, run_leap);
  assign ld_dim  = daysInMonth(bus.loadMonth, ld_leap);

  assign ld_ok = (bus.loadHours <= HOUR_MAX)
              && (bus.loadMinutes <= MIN_MAX)
              && (bus.loadSeconds <= SEC_MAX)
              && (bus.loadMonth >= JAN)
              && (bus.loadMonth <= MONTH_MAX)
              && (bus.loadDate != '0)
              && (bus.loadDate <= ld_dim)
              && (bus.loadYear >= YR_RST)
              && (bus.loadYear <= YR_END)
              && (bus.loadDay <= DAY_MAX);

  // Whole carry chain settles in one cycle; load beats tick.
  always_comb begin
    centi_d = centi_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    date_d  = date_q;
    month_d = month_q;
    year_d  = year_q;
    day_d   = day_q;
    sp_d    = 1'b0;
    roll_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      if (ld_ok) begin
        centi_d = '0;
        sec_d   = bus.loadSeconds;
        min_d   = bus.loadMinutes;
        hour_d  = bus.loadHours;
        date_d  = bus.loadDate;
        month_d = bus.loadMonth;
        year_d  = bus.loadYear;
        day_d   = bus.loadDay;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.tick100Hz) begin
      if (centi_q != CENTI_MAX) begin
        centi_d = centi_q + 1'b1;
      end else begin
        centi_d = '0;
        sp_d    = 1'b1;
        if (sec_q != SEC_MAX) begin
          sec_d = sec_q + 1'b1;
        end else begin
          sec_d = '0;
          if (min_q != MIN_MAX) begin
            min_d = min_q + 1'b1;
          end else begin
            min_d = '0;
            if (hour_q != HOUR_MAX) begin
              hour_d = hour_q + 1'b1;
            end else begin
              hour_d = '0;
              roll_d = 1'b1;
              day_d  = (day_q == DAY_MAX) ? '0 : day_q + 1'b1;
              if (date_q != run_dim) begin
                date_d = date_q + 1'b1;
              end else begin
                date_d = 5'd1;
                if (month_q != MONTH_MAX) begin
                  month_d = month_q + 1'b1;
                end else begin
                  month_d = JAN;
                  year_d  = (year_q == YR_END) ? YR_RST
                                               : year_q + 1'b1;
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      centi_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      date_q  <= 5'd1;
      month_q <= JAN;
      year_q  <= YR_RST;
      day_q   <= DW_RST;
      sp_q    <= 1'b0;
      roll_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      centi_q <= centi_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      date_q  <= date_d;
      month_q <= month_d;
      year_q  <= year_d;
      day_q   <= day_d;
      sp_q    <= sp_d;
      roll_q  <= roll_d;
      err_q   <= err_d;
    end
  end

  assign bus.centiDisplay   = centi_q;
  assign bus.secondsDisplay = sec_q;
  assign bus.minutesDisplay = min_q;
  assign bus.hoursDisplay   = hour_q;
  assign bus.dateDisplay    = date_q;
  assign bus.monthDisplay   = month_q;
  assign bus.yearDisplay    = year_q;
  assign bus.dayDisplay     = day_q;
  assign bus.secondPulse    = sp_q;
  assign bus.dayRollover    = roll_q;
  assign bus.loadError      = err_q;

`ifdef CALENDAR_ALARM_EN
  logic [HOUR_W-1:0] al_hour_q;
  logic [MIN_W-1:0]  al_min_q;
  logic armed_q, ring_q, ring_d, hit;

  // Only a counting tick can land on hh:mm:00.00 here.
  assign hit = armed_q
            && (centi_d == '0) && (sec_d == '0)
            && (min_d == al_min_q)
            && (hour_d == al_hour_q);

  always_comb begin
    ring_d = ring_q;
    if (!bus.alarmEnable) begin
      ring_d = 1'b0;
    end else if (bus.tick100Hz && !bus.load) begin
      if (hit) begin
        ring_d = 1'b1;
      end else if (min_d != al_min_q) begin
        ring_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      al_hour_q <= '0;
      al_min_q  <= '0;
      armed_q   <= 1'b0;
      ring_q    <= 1'b0;
    end else begin
      if (bus.alarmSet) begin
        al_hour_q <= bus.alarmHours;
        al_min_q  <= bus.alarmMinutes;
        armed_q   <= 1'b1;
      end
      ring_q <= ring_d;
    end
  end

  assign bus.alarmRing = ring_q;
`endif

endmodule

// File: tb/tb_calendar_time_counter.sv
// tb_calendar_time_counter: directed + random checks of the calendar.
// Reference keeps time as centiseconds-of-day plus a calendar date.
module tb_calendar_time_counter;

  localparam int R_YEAR = 1900;
  localparam int R_DAY  = 1;
  localparam int Y_MAX  = 9999;
  localparam int DAY_CS = 24 * 60 * 60 * 100;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  int tod, y, mo, d, dw;
  bit e_sp, e_roll, e_err;
`ifdef CALENDAR_ALARM_EN
  int ah, am;
  bit armed, e_ring;
`endif

  calendar_time_counter_if bus ();

  calendar_time_counter #(
    .RESET_YEAR (R_YEAR),
    .RESET_DAY  (R_DAY),
    .YEAR_MAX   (Y_MAX)
  ) dut (
    .clockSignal (clk),
    .resetN      (rstn),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic bit is_leap(int yr);
    return ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0);
  endfunction

  function automatic int dim(int m, int yr);
    if (m == 2) return is_leap(yr) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic bit load_ok(int h, int m, int s, int dt,
                                 int mn, int yr, int wd);
    if (h > 23 || m > 59 || s > 59) return 0;
    if (mn < 1 || mn > 12) return 0;
    if (yr < R_YEAR || yr > Y_MAX) return 0;
    if (dt < 1 || dt > dim(mn, yr)) return 0;
    return wd <= 6;
  endfunction

  task automatic model_reset();
    tod = 0; y = R_YEAR; mo = 1; d = 1; dw = R_DAY;
    e_sp = 0; e_roll = 0; e_err = 0;
`ifdef CALENDAR_ALARM_EN
    ah = 0; am = 0; armed = 0; e_ring = 0;
`endif
  endtask

  task automatic next_day();
    dw = (dw + 1) % 7;
    d++;
    if (d > dim(mo, y)) begin
      d = 1;
      mo++;
      if (mo > 12) begin
        mo = 1;
        y = (y == Y_MAX) ? R_YEAR : y + 1;
      end
    end
  endtask

  task automatic model_step(bit tk, bit ld);
    int lh, lm, ls, lt, lmo, ly, lw;
    lh = int'(bus.loadHours);   lm = int'(bus.loadMinutes);
    ls = int'(bus.loadSeconds); lt = int'(bus.loadDate);
    lmo = int'(bus.loadMonth);  ly = int'(bus.loadYear);
    lw = int'(bus.loadDay);
    e_sp = 0; e_roll = 0; e_err = 0;
    if (ld) begin
      if (load_ok(lh, lm, ls, lt, lmo, ly, lw)) begin
        tod = ((lh * 60 + lm) * 60 + ls) * 100;
        d = lt; mo = lmo; y = ly; dw = lw;
      end else begin
        e_err = 1;
      end
    end else if (tk) begin
      tod++;
      e_sp = (tod % 100 == 0);
      if (tod == DAY_CS) begin
        tod = 0;
        e_roll = 1;
        next_day();
      end
    end
`ifdef CALENDAR_ALARM_EN
    if (!bus.alarmEnable) e_ring = 0;
    else if (tk && !ld) begin
      if (armed && tod % 6000 == 0 && tod / 360000 == ah
          && (tod / 6000) % 60 == am) e_ring = 1;
      else if ((tod / 6000) % 60 != am) e_ring = 0;
    end
    if (bus.alarmSet) begin
      ah = int'(bus.alarmHours);
      am = int'(bus.alarmMinutes);
      armed = 1;
    end
`endif
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("centi", 32'(bus.centiDisplay), tod % 100);
    chk("sec", 32'(bus.secondsDisplay), (tod / 100) % 60);
    chk("min", 32'(bus.minutesDisplay), (tod / 6000) % 60);
    chk("hour", 32'(bus.hoursDisplay), tod / 360000);
    chk("date", 32'(bus.dateDisplay), d);
    chk("month", 32'(bus.monthDisplay), mo);
    chk("year", 32'(bus.yearDisplay), y);
    chk("day", 32'(bus.dayDisplay), dw);
    chk("secPulse", 32'(bus.secondPulse), 32'(e_sp));
    chk("dayRoll", 32'(bus.dayRollover), 32'(e_roll));
    chk("loadErr", 32'(bus.loadError), 32'(e_err));
`ifdef CALENDAR_ALARM_EN
    chk("ring", 32'(bus.alarmRing), 32'(e_ring));
`endif
  endtask

  task automatic cycle(bit tk, bit ld);
    bus.tick100Hz = tk;
    bus.load = ld;
    @(posedge clk);
    #1;
    model_step(tk, ld);
    bus.tick100Hz = 0;
    bus.load = 0;
`ifdef CALENDAR_ALARM_EN
    bus.alarmSet = 0;
`endif
    check_all();
  endtask

  task automatic ticks(int n);
    repeat (n) cycle(1, 0);
  endtask

  task automatic do_load(int h, int m, int s, int dt, int mn,
                         int yr, int wd, bit tk);
    bus.loadHours = 5'(h);   bus.loadMinutes = 6'(m);
    bus.loadSeconds = 6'(s); bus.loadDate = 5'(dt);
    bus.loadMonth = 4'(mn);  bus.loadYear = 14'(yr);
    bus.loadDay = 3'(wd);
    cycle(tk, 1);
  endtask

  task automatic random_load();
    int h, m, s, dt, mn, yr, wd;
    bit nearEnd;
    nearEnd = ($urandom_range(0, 1) == 1);
    h = nearEnd ? 23 : $urandom_range(0, 24);
    m = nearEnd ? 59 : $urandom_range(0, 60);
    s = nearEnd ? 59 : $urandom_range(0, 60);
    yr = ($urandom_range(0, 7) == 0) ? Y_MAX
                                     : $urandom_range(1890, 2110);
    mn = $urandom_range(0, 13);
    if (nearEnd && mn >= 1 && mn <= 12)
      dt = dim(mn, yr) + (($urandom_range(0, 5) == 0) ? 1 : 0);
    else
      dt = $urandom_range(0, 31);
    wd = $urandom_range(0, 7);
    do_load(h, m, s, dt, mn, yr, wd, $urandom_range(0, 3) == 0);
  endtask

  initial begin
    bus.tick100Hz = 0; bus.load = 0;
    bus.loadHours = 0; bus.loadMinutes = 0; bus.loadSeconds = 0;
    bus.loadDate = 1; bus.loadMonth = 1; bus.loadYear = 14'(R_YEAR);
    bus.loadDay = 0;
`ifdef CALENDAR_ALARM_EN
    bus.alarmSet = 0; bus.alarmHours = 0;
    bus.alarmMinutes = 0; bus.alarmEnable = 0;
`endif
    #1 rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rstn = 1'b1;

    ticks(100);
    chk("sec_after_100", 32'(bus.secondsDisplay), 1);

    do_load(23, 59, 59, 31, 12, 1999, 5, 0);
    ticks(100);
    chk("y2k_year", 32'(bus.yearDisplay), 2000);
    chk("y2k_day", 32'(bus.dayDisplay), 6);

    do_load(23, 59, 59, 28, 2, 2000, 0, 0);
    ticks(100);
    chk("feb2000", 32'(bus.dateDisplay), 29);
    do_load(23, 59, 59, 28, 2, 1900, 0, 0);
    ticks(100);
    chk("feb1900", 32'(bus.monthDisplay), 3);
    do_load(23, 59, 59, 28, 2, 2024, 0, 0);
    ticks(100);
    chk("feb2024", 32'(bus.dateDisplay), 29);
    do_load(23, 59, 59, 28, 2, 2100, 3, 0);
    ticks(100);

    do_load(23, 59, 59, 31, 12, Y_MAX, 2, 0);
    ticks(100);
    chk("yearWrap", 32'(bus.yearDisplay), R_YEAR);

    ticks(37);
    do_load(10, 20, 30, 31, 4, 2021, 1, 0);
    chk("badDate_err", 32'(bus.loadError), 1);
    do_load(24, 0, 0, 1, 1, 2021, 1, 0);
    cycle(0, 0);
    do_load(5, 5, 59, 29, 2, 2023, 1, 0);
    do_load(5, 5, 5, 1, 1, 1899, 1, 0);
    do_load(5, 5, 5, 1, 1, 10000, 1, 0);
    do_load(5, 5, 5, 1, 0, 2000, 1, 0);
    do_load(5, 5, 5, 1, 1, 2000, 7, 0);

    do_load(12, 34, 10, 15, 6, 2010, 2, 1);
    chk("ldTick_sec", 32'(bus.secondsDisplay), 10);
    chk("ldTick_centi", 32'(bus.centiDisplay), 0);

    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 149) == 0) random_load();
      else cycle($urandom_range(0, 7) != 0, 0);
    end

`ifdef CALENDAR_ALARM_EN
    bus.alarmEnable = 1;
    bus.alarmSet = 1; bus.alarmHours = 7; bus.alarmMinutes = 30;
    cycle(0, 0);
    do_load(7, 29, 59, 1, 1, 2000, 6, 0);
    ticks(100);
    chk("alarmRise", 32'(bus.alarmRing), 1);
    ticks(50);
    bus.alarmEnable = 0;
    cycle(0, 0);
    chk("alarmOff", 32'(bus.alarmRing), 0);
    bus.alarmEnable = 1;
    do_load(7, 30, 0, 1, 1, 2000, 6, 0);
    ticks(20);
    chk("alarmLoad", 32'(bus.alarmRing), 0);
`endif

    ticks(250);
    #3 rstn = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1 rstn = 1'b1;
    ticks(5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calendar_time_counter.md
Name: calendar_time_counter

Overview:
- Downstream stage of the stopwatch/timer block: converts the 100 Hz count-enable into a running wall-clock time and calendar for the clock/date display mode.
- Cascaded counters: centiseconds → seconds → minutes → hours → date/day-of-week → month → year, with Gregorian leap-year handling.
- Supports a synchronous load of a user-set time/date, with validation.
- Outputs are registered and drive the display mux directly.

Parameters:
- RESET_YEAR, 1970: year value after reset.
- RESET_DAY, 4: day-of-week after reset (0 = Sunday … 6 = Saturday; 1 Jan 1970 is a Thursday).
- YEAR_MAX, 9999: the last year; incrementing past it wraps to RESET_YEAR.

Ports:
- clockSignal  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- tick100Hz  in  1  one-cycle count-enable pulse, nominally 100 Hz.
- load  in  1  one-cycle pulse; captures the load* fields.
- loadHours  in  5  hours, 0-23.
- loadMinutes  in  6  minutes, 0-59.
- loadSeconds  in  6  seconds, 0-59.
- loadDate  in  5  date, 1-31.
- loadMonth  in  4  month, 1-12.
- loadYear  in  14  year, RESET_YEAR..YEAR_MAX.
- loadDay  in  3  day of week, 0-6.
- centiDisplay  out  7  centiseconds, 0-99.
- secondsDisplay  out  6  seconds.
- minutesDisplay  out  6  minutes.
- hoursDisplay  out  5  hours.
- dateDisplay  out  5  date.
- monthDisplay  out  4  month.
- yearDisplay  out  14  year.
- dayDisplay  out  3  day of week.
- secondPulse  out  1  one cycle, high when seconds advance.
- dayRollover  out  1  one cycle, high at the 23:59:59.99 → 00:00:00.00 transition.
- loadError  out  1  one cycle, high when a load is rejected.

Behaviour:
- Clocking and reset:
  - Single clock domain. resetN low asynchronously forces all state.
  - Reset values: 00:00:00.00, date 1, month 1, year RESET_YEAR, day RESET_DAY; secondPulse, dayRollover and loadError all 0.
- Latency: all outputs are registered. A tick100Hz sampled high in cycle N is visible on the outputs in cycle N+1. Pulses also assert in cycle N+1.
- Cascade per tick:
  - centi 99 → 0 carries into seconds.
  - seconds 59 → 0 carries into minutes.
  - minutes 59 → 0 carries into hours.
  - hours 23 → 0 carries into date and advances day (6 → 0).
  - date == daysInMonth → 1 carries into month.
  - month 12 → 1 carries into year.
  - year == YEAR_MAX → RESET_YEAR.
  - All carries of one tick resolve in the same cycle; no multi-cycle ripple.
- Days in month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February is 29 if leap, else 28.
  - Leap rule: (y%4==0 && y%100!=0) || y%400==0.
- Load:
  - Validated in the same cycle it is sampled: hours ≤ 23, minutes/seconds ≤ 59, 1 ≤ month ≤ 12, 1 ≤ date ≤ daysInMonth(loadMonth, loadYear), RESET_YEAR ≤ loadYear ≤ YEAR_MAX, loadDay ≤ 6.
  - Valid load: all fields are written and centi is cleared to 0.
  - Invalid load: state is unchanged and loadError pulses in cycle N+1.
  - Day of week is taken as given; it is not cross-checked against the date.
- Simultaneous load and tick: load has priority and the tick is discarded; no carry occurs in that cycle.
- A tick asserted every cycle is legal; the counter advances once per cycle.
- A tick held high for k cycles advances k centiseconds. There is no edge detection; the upstream stage guarantees pulses.
- No pause input: the wall clock always runs. Pausing belongs to the stopwatch/timer block.

Optional Feature:
- Macro CALENDAR_ALARM_EN.
- When defined, it adds ports:
  - alarmSet in 1
  - alarmHours in 5
  - alarmMinutes in 6
  - alarmEnable in 1
  - alarmRing out 1
- alarmSet latches alarmHours and alarmMinutes into registers. Reset values of these registers are 0, and alarm armed = 0.
- On the tick that makes the time hh:mm:00.00 with hh:mm equal to the stored alarm, and alarmEnable high, alarmRing goes high.
- alarmRing stays high until alarmEnable falls or 60 s elapse. It is cleared at the first tick with minutes ≠ stored alarm minute.
- A load that jumps exactly onto the alarm time does not ring; only counting ticks ring.
- When not defined, these ports and registers do not exist.

Decomposition:
- Package calendar_pkg holds:
  - Field widths: CENTI_W = 7, SEC_W = 6, MIN_W = 6, HOUR_W = 5, DATE_W = 5, MONTH_W = 4, YEAR_W = 14, DAY_W = 3.
  - Field limits: 99, 59, 23, 12.
  - Month constants FEB = 2 etc.
  - Function daysInMonth(month, leap).
- Sub-module leap_year_check: combinational, year in → leap out. It is instantiated twice: once for the running year and once for loadYear validation.

Test Plan:
- Reset then 100 ticks → secondsDisplay = 1, centiDisplay = 0, secondPulse high exactly once, in the cycle after the 100th tick.
- Load 23:59:59, 31/12/1999, day 5, then 100 ticks → 00:00:00.00, 1/1/2000, day 6; dayRollover is a single pulse.
- Load 23:59:59 on 28/2 for years 2000, 1900 and 2024 (day 0), then 100 ticks → date 29/2, 1/3 and 29/2 respectively.
- Load date 31, month 4, year 2021 → loadError pulses one cycle and all outputs keep their prior values. Load hours = 24 → same response.
- Assert load and tick100Hz in the same cycle with loadSeconds = 10 → secondsDisplay = 10 and centiDisplay = 0. Then drop resetN mid-count → outputs go to reset values immediately, without waiting for a clock edge.
- With CALENDAR_ALARM_EN: alarm 07:30, load 07:29:59, then 100 ticks → alarmRing rises. Deassert alarmEnable → alarmRing clears next cycle.
